maxpool_stream: RTL and testbench
=================================

# maxpool_stream

Streaming max-pool reducer for the NPU datapath: consumes a stream of DATA_W-bit activations, reduces each group of WIN consecutive samples to its maximum, and emits one result per window with the in-window position of that maximum. Sits between the activation read path and the write-back buffer. Successor to the single-pair registered max comparator: parametrised width and window, signed/unsigned mode, valid/ready handshake on both sides, and window abort.

## Interface

Parameters:
- DATA_W, 16, sample and result width in bits (≥2)
- WIN, 4, samples per window (≥1)
- IDX_W, max(1, clog2(WIN)), width of the index field and of the window counter

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset, asynchronous, active-high; clears all state
- CLR_POOL  in  1  synchronous abort of the current window
- EN_SIGNED  in  1  1 = two's-complement compare, 0 = unsigned
- In_Data  in  DATA_W  input sample
- In_Valid  in  1  In_Data valid
- In_Ready  out  1  block accepts a sample this cycle
- Out_Data  out  DATA_W  window maximum
- Out_Index  out  IDX_W  position (0..WIN-1) of the maximum within its window
- Out_Valid  out  1  Out_Data/Out_Index valid
- Out_Ready  in  1  downstream accepts the result

## Operation

- Transfer on either side occurs when valid and ready are both high at a rising edge.
- State: window counter cnt (0..WIN-1), running max acc, running index acc_idx, latched mode acc_sgn, output register (Out_Data, Out_Index, Out_Valid).
- Two states: IDLE (cnt = 0, no partial window) and ACCUM (cnt > 0).
- In IDLE, an accepted sample loads acc = In_Data, acc_idx = 0, acc_sgn = EN_SIGNED; cnt advances to 1.
- In ACCUM, an accepted sample replaces acc/acc_idx with In_Data/cnt only if strictly greater under acc_sgn. Ties keep the earlier sample, so the lowest index wins. EN_SIGNED is ignored after the first sample of a window.
- Accepting sample number WIN-1 (the last one) does three things:
  - loads the output register with the final max/index, evaluated against that sample;
  - sets Out_Valid;
  - returns cnt to 0 (IDLE).
- For WIN = 1, every accepted sample passes straight to the output register with index 0.
- In_Ready = ~Out_Valid | Out_Ready. The output register is a single slot; input stalls only while a result is held and not taken.
- Out_Valid clears on an output transfer unless a new result is loaded in the same cycle, in which case it stays 1 with new data.
- Out_Data and Out_Index hold stable while Out_Valid = 1 and Out_Ready = 0.
- CLR_POOL = 1:
  - discards the partial window: cnt = 0, acc and acc_idx cleared;
  - no sample is accepted that cycle, and In_Ready is forced to 0;
  - a pending output result is not affected.
- RST: cnt, acc, acc_idx, acc_sgn, Out_Data, Out_Index and Out_Valid all go to 0 immediately, mid-window or mid-handshake. In_Ready then reads 1.

## Timing

- Latency: Out_Valid rises on the edge that accepts the last sample of a window, i.e. it is visible in the following cycle.
- Throughput: 1 sample/cycle sustained with Out_Ready held high; one result every WIN cycles.
- In_Ready is combinational from Out_Valid, Out_Ready and CLR_POOL only; it has no path from In_Valid.
- Out_* are register outputs with no combinational path from inputs.
- Reset values: Out_Data = 0, Out_Index = 0, Out_Valid = 0, In_Ready = 1 (with CLR_POOL = 0).

## Configuration

- POOL_ARGMAX_EN defined:
  - acc_idx and the Out_Index register are built;
  - Out_Index reports the position of the maximum as above.
- POOL_ARGMAX_EN undefined:
  - no index storage;
  - Out_Index is tied to 0;
  - Out_Data, handshake and timing are identical.

## Test plan

- Unsigned, DATA_W=16, WIN=4, Out_Ready=1: samples 0x0003, 0x00F0, 0x0010, 0x0001 -> one result, Out_Data=0x00F0, Out_Index=1, Out_Valid high for exactly 1 cycle, the cycle after sample 4.
- Signed vs unsigned: samples 0xFFFF, 0x0002, 0x8000, 0x0001 -> EN_SIGNED=1 gives 0x0002, idx 1; EN_SIGNED=0 gives 0xFFFF, idx 0. Toggling EN_SIGNED after sample 1 does not change either result.
- Ties: samples 0x0005, 0x0007, 0x0007, 0x0007 -> Out_Data=0x0007, Out_Index=1.
- Backpressure: stream 12 samples back-to-back with Out_Ready=0 until the first result is pending.
  - In_Ready drops after window 1 completes.
  - Out_* are stable while stalled.
  - Releasing Out_Ready drains 3 correct results in order, with no sample lost or duplicated.
- CLR_POOL after 2 of 4 samples, then 4 new samples 0x0001..0x0004 -> a single result 0x0004, idx 3. The aborted partial window produces no output.
- Async RST asserted between edges mid-window with Out_Valid=1 -> Out_Valid, Out_Data and Out_Index are 0 before the next edge. After release, the next window of 4 samples is reduced correctly from index 0. Repeat with POOL_ARGMAX_EN undefined and check Out_Index=0 throughout.

Source files
------------

// File: rtl/maxpool_stream_if.sv
// Handshake bundle for maxpool_stream: sample input stream and result output stream.
// The slave modport is the reducer's view; master is the producer/consumer side.
interface maxpool_stream_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 2
);
    logic [DATA_W-1:0] In_Data;
    logic              In_Valid;
    logic              In_Ready;
    logic [DATA_W-1:0] Out_Data;
    logic [IDX_W-1:0]  Out_Index;
    logic              Out_Valid;
    logic              Out_Ready;

    modport master (
        output In_Data, In_Valid, Out_Ready,
        input  In_Ready, Out_Data, Out_Index, Out_Valid
    );

    modport slave (
        input  In_Data, In_Valid, Out_Ready,
        output In_Ready, Out_Data, Out_Index, Out_Valid
    );
endinterface

// File: rtl/maxpool_stream.sv
// Streaming max-pool reducer: one max (and argmax position) per WIN-sample window.
// Define POOL_ARGMAX_EN to build index tracking; otherwise Out_Index is tied to 0.
module maxpool_stream #(
    parameter int DATA_W = 16,
    parameter int WIN    = 4,
    parameter int IDX_W  = (WIN > 1) ? $clog2(WIN) : 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            CLR_POOL,
    input  logic            EN_SIGNED,
    maxpool_stream_if.slave bus
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    w_cnt_nxt;
    logic [DATA_W-1:0]   r_acc;
    logic [DATA_W-1:0]   w_acc_nxt;
    logic                r_acc_sgn;
    logic                w_acc_sgn_nxt;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_valid;

    logic                w_in_ready;
    logic                w_accept;
    logic                w_out_fire;
    logic                w_gt;
    logic                w_take_new;
    logic                w_last;
    logic                w_load_out;
    logic [DATA_W-1:0]   w_cand_data;

`ifdef POOL_ARGMAX_EN
    logic [IDX_W-1:0]    r_acc_idx;
    logic [IDX_W-1:0]    w_acc_idx_nxt;
    logic [IDX_W-1:0]    r_out_idx;
    logic [IDX_W-1:0]    w_cand_idx;
`endif

    // Input stalls only while a held result is not being taken, or during an abort.
    assign w_in_ready = (~r_out_valid | bus.Out_Ready) & ~CLR_POOL;
    assign w_accept   = bus.In_Valid & w_in_ready;
    assign w_out_fire = r_out_valid & bus.Out_Ready;

    // Strictly-greater compare keeps the earlier sample on ties (lowest index wins).
    assign w_gt = r_acc_sgn ? ($signed(bus.In_Data) > $signed(r_acc))
                            : (bus.In_Data > r_acc);
    assign w_take_new  = (r_state == S_IDLE) | w_gt;
    assign w_cand_data = w_take_new ? bus.In_Data : r_acc;
    assign w_last      = (r_cnt == LAST_IDX);

`ifdef POOL_ARGMAX_EN
    assign w_cand_idx = (r_state == S_IDLE) ? '0 : (w_gt ? r_cnt : r_acc_idx);
`endif

    always_comb begin
        // NOTE: every variable gets its default first so no path leaves one unassigned and no latch is inferred.
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_acc_nxt     = r_acc;
        w_acc_sgn_nxt = r_acc_sgn;
        w_load_out    = 1'b0;
`ifdef POOL_ARGMAX_EN
        w_acc_idx_nxt = r_acc_idx;
`endif
        if (CLR_POOL) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_acc_nxt   = '0;
`ifdef POOL_ARGMAX_EN
            w_acc_idx_nxt = '0;
`endif
        end else if (w_accept) begin
            w_acc_nxt = w_cand_data;
`ifdef POOL_ARGMAX_EN
            w_acc_idx_nxt = w_cand_idx;
`endif
            // Compare mode is latched from the first sample and frozen for the window.
            if (r_state == S_IDLE) begin
                w_acc_sgn_nxt = EN_SIGNED;
            end
            if (w_last) begin
                w_load_out  = 1'b1;
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end else begin
                w_state_nxt = S_ACCUM;
                w_cnt_nxt   = r_cnt + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (RST) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_acc_sgn <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_acc     <= w_acc_nxt;
            r_acc_sgn <= w_acc_sgn_nxt;
        end
    end

    // A new result may overwrite the slot in the same cycle the old one is taken.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_load_out) begin
            r_out_data  <= w_cand_data;
            r_out_valid <= 1'b1;
        end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef POOL_ARGMAX_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_acc_idx <= '0;
            r_out_idx <= '0;
        end else begin
            r_acc_idx <= w_acc_idx_nxt;
            if (w_load_out) begin
                r_out_idx <= w_cand_idx;
            end
        end
    end

    assign bus.Out_Index = r_out_idx;
`else
    assign bus.Out_Index = '0;
`endif

    assign bus.In_Ready  = w_in_ready;
    assign bus.Out_Data  = r_out_data;
    assign bus.Out_Valid = r_out_valid;

endmodule

// File: tb/tb_maxpool_stream.sv
// Directed self-checking bench for maxpool_stream (DATA_W=16, WIN=4); index
// expectations fold to 0 when POOL_ARGMAX_EN is not defined.
module tb_maxpool_stream;

    logic CLK;
    logic RST;
    logic CLR_POOL;
    logic EN_SIGNED;

    int n_checks = 0;
    int n_pass   = 0;

    maxpool_stream_if #(.DATA_W(16), .IDX_W(2)) bus ();

    maxpool_stream #(.DATA_W(16), .WIN(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .CLR_POOL  (CLR_POOL),
        .EN_SIGNED (EN_SIGNED),
        .bus       (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic int exp_idx(input int i);
`ifdef POOL_ARGMAX_EN
        return i;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Called just after a rising edge; returns just after the edge that accepted d.
    task automatic push(input logic [15:0] d);
        int waited;
        waited = 0;
        bus.In_Data  = d;
        bus.In_Valid = 1'b1;
        @(negedge CLK);
        while (!bus.In_Ready && waited < 50) begin
            @(negedge CLK);
            waited++;
        end
        if (!bus.In_Ready) check("push_ready_timeout", 32'(bus.In_Ready), 1);
        @(posedge CLK);
        #1;
        bus.In_Valid = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [31:0] d, input int idx);
        @(negedge CLK);
        check({tag, "_valid"}, 32'(bus.Out_Valid), 1);
        check({tag, "_data"},  32'(bus.Out_Data), d);
        check({tag, "_idx"},   32'(bus.Out_Index), exp_idx(idx));
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_idle(input string tag);
        @(negedge CLK);
        check(tag, 32'(bus.Out_Valid), 0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST           = 1'b1;
        CLR_POOL      = 1'b0;
        EN_SIGNED     = 1'b0;
        bus.In_Data   = '0;
        bus.In_Valid  = 1'b0;
        bus.Out_Ready = 1'b0;

        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("reset_valid",    32'(bus.Out_Valid), 0);
        check("reset_data",     32'(bus.Out_Data), 0);
        check("reset_idx",      32'(bus.Out_Index), 0);
        check("reset_in_ready", 32'(bus.In_Ready), 1);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Basic unsigned window, result valid for exactly one cycle
        bus.Out_Ready = 1'b1;
        push(16'h0003);
        push(16'h00F0);
        push(16'h0010);
        expect_idle("t1_no_early_valid");
        push(16'h0001);
        expect_result("t1", 'h00F0, 1);
        expect_idle("t1_one_cycle");

        // Signed mode latched from first sample; toggling later has no effect
        EN_SIGNED = 1'b1;
        push(16'hFFFF);
        EN_SIGNED = 1'b0;
        push(16'h0002);
        push(16'h8000);
        push(16'h0001);
        expect_result("signed", 'h0002, 1);

        EN_SIGNED = 1'b0;
        push(16'hFFFF);
        EN_SIGNED = 1'b1;
        push(16'h0002);
        push(16'h8000);
        push(16'h0001);
        expect_result("unsigned", 'hFFFF, 0);
        EN_SIGNED = 1'b0;

        // Ties keep the earliest position
        push(16'h0005);
        push(16'h0007);
        push(16'h0007);
        push(16'h0007);
        expect_result("ties", 'h0007, 1);

        // Backpressure: three windows with the first result held
        bus.Out_Ready = 1'b0;
        push(16'h0010);
        push(16'h0040);
        push(16'h0020);
        push(16'h0030);
        bus.In_Data  = 16'h0009;
        bus.In_Valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("bp_in_ready_low", 32'(bus.In_Ready), 0);
            check("bp_hold_valid",   32'(bus.Out_Valid), 1);
            check("bp_hold_data",    32'(bus.Out_Data), 'h0040);
            check("bp_hold_idx",     32'(bus.Out_Index), exp_idx(1));
        end
        // Abort while a result is pending leaves the result intact
        @(posedge CLK);
        #1;
        CLR_POOL = 1'b1;
        @(negedge CLK);
        check("bp_clr_keeps_valid", 32'(bus.Out_Valid), 1);
        check("bp_clr_keeps_data",  32'(bus.Out_Data), 'h0040);
        @(posedge CLK);
        #1;
        CLR_POOL      = 1'b0;
        bus.Out_Ready = 1'b1;
        @(posedge CLK);
        #1;
        bus.In_Valid = 1'b0;
        expect_idle("bp_drained");
        push(16'h0008);
        push(16'h0007);
        push(16'h0006);
        expect_result("bp_w2", 'h0009, 0);
        push(16'h0001);
        push(16'h0002);
        push(16'h0003);
        push(16'h0050);
        expect_result("bp_w3", 'h0050, 3);

        // Window abort after two samples
        push(16'h0100);
        push(16'h0200);
        CLR_POOL     = 1'b1;
        bus.In_Data  = 16'h0FFF;
        bus.In_Valid = 1'b1;
        @(negedge CLK);
        check("clr_in_ready_low", 32'(bus.In_Ready), 0);
        @(posedge CLK);
        #1;
        CLR_POOL     = 1'b0;
        bus.In_Valid = 1'b0;
        expect_idle("clr_no_output");
        push(16'h0001);
        push(16'h0002);
        push(16'h0003);
        expect_idle("clr_no_early_valid");
        push(16'h0004);
        expect_result("clr", 'h0004, 3);

        // Async reset between edges with a result pending
        bus.Out_Ready = 1'b0;
        push(16'h0005);
        push(16'h0006);
        push(16'h0007);
        push(16'h0008);
        @(negedge CLK);
        check("rst_pre_valid", 32'(bus.Out_Valid), 1);
        #1;
        RST = 1'b1;
        #1;
        check("rst_async_valid",    32'(bus.Out_Valid), 0);
        check("rst_async_data",     32'(bus.Out_Data), 0);
        check("rst_async_idx",      32'(bus.Out_Index), 0);
        check("rst_async_in_ready", 32'(bus.In_Ready), 1);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Async reset mid-window discards the partial window
        bus.Out_Ready = 1'b1;
        push(16'h0900);
        push(16'h0901);
        @(negedge CLK);
        #1;
        RST = 1'b1;
        #1;
        check("rst_mid_valid", 32'(bus.Out_Valid), 0);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        push(16'h0003);
        push(16'h0001);
        push(16'h0004);
        expect_idle("rst_no_early_valid");
        push(16'h0001);
        expect_result("rst_after", 'h0004, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
